// File: rtl/exception_unit_if.sv
// rtl/exception_unit_if.sv - pipeline/cop0 signal bundle for exception_unit
interface exception_unit_if;
  // memory-stage instruction and its cause flags
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic        ex_fetch_adel;
  logic        ex_ri;
  logic        ex_ov;
  logic        ex_sys;
  logic        ex_bp;
  logic        ex_eret;
  logic        ex_load_adel;
  logic        ex_store_ades;
  logic [31:0] mem_addr;
  logic        mem_stall;
  // cop0 status and external interrupt lines
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic [31:0] epc_address;
  logic [5:0]  irq;
  // commit request towards cop0
  logic        exp_en;
  logic        exp_badvaddr_en;
  logic [31:0] exp_badvaddr;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exl_clean;
  logic [5:0]  hint;
  // pipeline control
  logic        exc_stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_valid, mem_pc, mem_bd, ex_fetch_adel, ex_ri, ex_ov, ex_sys, ex_bp,
           ex_eret, ex_load_adel, ex_store_ades, mem_addr, mem_stall,
           allow_interrupt, interrupt_flag, epc_address, irq,
    input  exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
           exl_clean, hint, exc_stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_valid, mem_pc, mem_bd, ex_fetch_adel, ex_ri, ex_ov, ex_sys, ex_bp,
           ex_eret, ex_load_adel, ex_store_ades, mem_addr, mem_stall,
           allow_interrupt, interrupt_flag, epc_address, irq,
    output exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
           exl_clean, hint, exc_stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - memory-stage exception arbiter and cop0 commit sequencer (optional EXC_IRQ_SYNC_EN)
module exception_unit (
  input  logic             clk,
  input  logic             rst,
  exception_unit_if.slave  bus
);

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

  state_t      state;
  state_t      state_next;

  logic        int_pending;
  logic        any_flag;
  logic        detect;

  logic [4:0]  win_code;
  logic        win_badv_en;
  logic [31:0] win_badv;
  logic        win_eret;
  logic [31:0] win_epc;

  logic [4:0]  cap_code;
  logic        cap_bd;
  logic [31:0] cap_epc;
  logic        cap_badv_en;
  logic [31:0] cap_badv;
  logic        cap_eret;

  // raw detect: any cause on a valid memory-stage instruction
  always_comb begin
    int_pending = bus.allow_interrupt && (|bus.interrupt_flag);
    any_flag    = bus.ex_fetch_adel | bus.ex_ri | bus.ex_ov | bus.ex_sys | bus.ex_bp |
                  bus.ex_eret | bus.ex_load_adel | bus.ex_store_ades;
    detect      = bus.mem_valid && (any_flag || int_pending);
  end

  // fixed-priority pick of the single cause to report
  always_comb begin
    win_code    = 5'h00;
    win_badv_en = 1'b0;
    win_badv    = 32'h0;
    win_eret    = 1'b0;
    if (int_pending) begin
      win_code = 5'h00;
    end else if (bus.ex_fetch_adel) begin
      win_code    = 5'h04;
      win_badv_en = 1'b1;
      win_badv    = bus.mem_pc;
    end else if (bus.ex_ri) begin
      win_code = 5'h0a;
    end else if (bus.ex_ov) begin
      win_code = 5'h0c;
    end else if (bus.ex_sys) begin
      win_code = 5'h08;
    end else if (bus.ex_bp) begin
      win_code = 5'h09;
    end else if (bus.ex_eret) begin
      win_code = 5'h00;
      win_eret = 1'b1;
    end else if (bus.ex_load_adel) begin
      win_code    = 5'h04;
      win_badv_en = 1'b1;
      win_badv    = bus.mem_addr;
    end else if (bus.ex_store_ades) begin
      win_code    = 5'h05;
      win_badv_en = 1'b1;
      win_badv    = bus.mem_addr;
    end
    // eret rewrites EPC with its current value so cop0 leaves it unchanged
    if (win_eret) begin
      win_epc = bus.epc_address;
    end else if (bus.mem_bd) begin
      win_epc = bus.mem_pc - 32'd4;
    end else begin
      win_epc = bus.mem_pc;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // capture the winning cause once, on the IDLE->COMMIT transition
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_code    <= 5'h00;
      cap_bd      <= 1'b0;
      cap_epc     <= 32'h0;
      cap_badv_en <= 1'b0;
      cap_badv    <= 32'h0;
      cap_eret    <= 1'b0;
    end else if (state == IDLE && detect) begin
      cap_code    <= win_code;
      cap_bd      <= win_eret ? 1'b0 : bus.mem_bd;
      cap_epc     <= win_epc;
      cap_badv_en <= win_badv_en;
      cap_badv    <= win_badv;
      cap_eret    <= win_eret;
    end
  end

  // next state and per-state outputs; inputs are ignored outside IDLE
  always_comb begin
    state_next          = state;
    bus.exp_en          = 1'b0;
    bus.exp_badvaddr_en = 1'b0;
    bus.exp_badvaddr    = 32'h0;
    bus.exp_bd          = 1'b0;
    bus.exp_code        = 5'h00;
    bus.exp_epc         = 32'h0;
    bus.exl_clean       = 1'b0;
    bus.exc_stall       = 1'b0;
    bus.flush           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    case (state)
      IDLE: begin
        bus.exc_stall = detect;
        if (detect) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        bus.exc_stall       = 1'b1;
        bus.exp_en          = 1'b1;
        bus.exp_badvaddr_en = cap_badv_en;
        bus.exp_badvaddr    = cap_badv;
        bus.exp_bd          = cap_bd;
        bus.exp_code        = cap_code;
        bus.exp_epc         = cap_epc;
        bus.exl_clean       = cap_eret;
        if (!bus.mem_stall) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        bus.exc_stall      = 1'b1;
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = cap_eret ? cap_epc : EXC_VECTOR;
        state_next         = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef EXC_IRQ_SYNC_EN
  logic [5:0] irq_meta;
  logic [5:0] irq_sync;

  // two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_meta <= 6'h00;
      irq_sync <= 6'h00;
    end else begin
      irq_meta <= bus.irq;
      irq_sync <= irq_meta;
    end
  end

  assign bus.hint = irq_sync;
`else
  assign bus.hint = bus.irq;
`endif

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - self-checking bench for exception_unit
module tb_exception_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exception_unit_if bus ();

  exception_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        badv_en;
    logic [31:0] badv;
    logic        eret;
    logic [31:0] target;
  } rec_t;

  // cause table in priority order: interrupt, fetch, ri, ov, sys, bp, eret, load, store
  localparam logic [4:0] CODES [9] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h00, 5'h04, 5'h05};

  rec_t       m_rec;
  bit         m_busy;
  bit         m_redirect;
  logic [5:0] m_irq1;
  logic [5:0] m_irq2;

  function automatic bit m_detect();
    return bus.mem_valid && (bus.ex_fetch_adel || bus.ex_ri || bus.ex_ov || bus.ex_sys ||
           bus.ex_bp || bus.ex_eret || bus.ex_load_adel || bus.ex_store_ades ||
           (bus.allow_interrupt && bus.interrupt_flag != 8'h00));
  endfunction

  function automatic rec_t judge();
    rec_t r;
    bit   hits [9];
    int   w;
    hits[0] = bus.allow_interrupt && bus.interrupt_flag != 8'h00;
    hits[1] = bus.ex_fetch_adel;
    hits[2] = bus.ex_ri;
    hits[3] = bus.ex_ov;
    hits[4] = bus.ex_sys;
    hits[5] = bus.ex_bp;
    hits[6] = bus.ex_eret;
    hits[7] = bus.ex_load_adel;
    hits[8] = bus.ex_store_ades;
    w = 8;
    for (int i = 8; i >= 0; i--) if (hits[i]) w = i;
    r.code    = CODES[w];
    r.eret    = (w == 6);
    r.badv_en = (w == 1 || w == 7 || w == 8);
    r.badv    = (w == 1) ? bus.mem_pc : (r.badv_en ? bus.mem_addr : 32'h0);
    r.bd      = r.eret ? 1'b0 : bus.mem_bd;
    r.epc     = r.eret ? bus.epc_address : (bus.mem_bd ? bus.mem_pc + 32'hFFFFFFFC : bus.mem_pc);
    r.target  = r.eret ? bus.epc_address : 32'hBFC00380;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy     = 1'b0;
      m_redirect = 1'b0;
      m_rec      = '{default: '0};
      m_irq1     = 6'h00;
      m_irq2     = 6'h00;
    end else begin
      m_irq2 = m_irq1;
      m_irq1 = bus.irq;
      if (m_redirect) begin
        m_redirect = 1'b0;
      end else if (m_busy) begin
        if (!bus.mem_stall) begin
          m_busy     = 1'b0;
          m_redirect = 1'b1;
        end
      end else if (m_detect()) begin
        m_rec  = judge();
        m_busy = 1'b1;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check("exp_en",          {31'h0, bus.exp_en},          {31'h0, m_busy});
      check("exp_code",        {27'h0, bus.exp_code},        m_busy ? {27'h0, m_rec.code} : 32'h0);
      check("exp_bd",          {31'h0, bus.exp_bd},          {31'h0, m_busy && m_rec.bd});
      check("exp_epc",         bus.exp_epc,                  m_busy ? m_rec.epc : 32'h0);
      check("exp_badvaddr_en", {31'h0, bus.exp_badvaddr_en}, {31'h0, m_busy && m_rec.badv_en});
      check("exp_badvaddr",    bus.exp_badvaddr,             m_busy ? m_rec.badv : 32'h0);
      check("exl_clean",       {31'h0, bus.exl_clean},       {31'h0, m_busy && m_rec.eret});
      check("flush",           {31'h0, bus.flush},           {31'h0, m_redirect});
      check("redirect_valid",  {31'h0, bus.redirect_valid},  {31'h0, m_redirect});
      check("redirect_pc",     bus.redirect_pc,              m_redirect ? m_rec.target : 32'h0);
      check("exc_stall",       {31'h0, bus.exc_stall},       {31'h0, m_busy || m_redirect || m_detect()});
`ifdef EXC_IRQ_SYNC_EN
      check("hint",            {26'h0, bus.hint},            {26'h0, m_irq2});
`else
      check("hint",            {26'h0, bus.hint},            {26'h0, bus.irq});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    bus.mem_valid       = 1'b0;
    bus.mem_pc          = 32'h0;
    bus.mem_bd          = 1'b0;
    bus.ex_fetch_adel   = 1'b0;
    bus.ex_ri           = 1'b0;
    bus.ex_ov           = 1'b0;
    bus.ex_sys          = 1'b0;
    bus.ex_bp           = 1'b0;
    bus.ex_eret         = 1'b0;
    bus.ex_load_adel    = 1'b0;
    bus.ex_store_ades   = 1'b0;
    bus.mem_addr        = 32'h0;
    bus.mem_stall       = 1'b0;
    bus.allow_interrupt = 1'b0;
    bus.interrupt_flag  = 8'h00;
    bus.epc_address     = 32'h0;
    bus.irq             = 6'h00;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int en_cnt;
  int fl_cnt;

  initial begin
    idle_in();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    @(negedge clk);
    check("reset exp_en", {31'h0, bus.exp_en}, 32'h0);
    check("reset flush", {31'h0, bus.flush}, 32'h0);
    check("reset hint", {26'h0, bus.hint}, 32'h0);

    // overflow, no delay slot
    nxt(); rst = 1'b1;
    bus.mem_valid = 1'b1; bus.ex_ov = 1'b1; bus.mem_pc = 32'h80001000;
    @(negedge clk);
    check("ov exc_stall", {31'h0, bus.exc_stall}, 32'h1);
    nxt(); idle_in();
    @(negedge clk);
    check("ov exp_en", {31'h0, bus.exp_en}, 32'h1);
    check("ov code", {27'h0, bus.exp_code}, 32'h0c);
    check("ov epc", bus.exp_epc, 32'h80001000);
    nxt();
    @(negedge clk);
    check("ov redirect", bus.redirect_pc, 32'hBFC00380);
    check("ov flush", {31'h0, bus.flush}, 32'h1);
    nxt();
    @(negedge clk);
    check("ov back idle", {31'h0, bus.exc_stall}, 32'h0);

    // load AdEL in delay slot
    bus.mem_valid = 1'b1; bus.ex_load_adel = 1'b1; bus.mem_addr = 32'h3;
    bus.mem_bd = 1'b1; bus.mem_pc = 32'h80000020;
    nxt(); idle_in();
    @(negedge clk);
    check("ld badv_en", {31'h0, bus.exp_badvaddr_en}, 32'h1);
    check("ld badv", bus.exp_badvaddr, 32'h3);
    check("ld bd", {31'h0, bus.exp_bd}, 32'h1);
    check("ld epc", bus.exp_epc, 32'h8000001C);
    check("ld code", {27'h0, bus.exp_code}, 32'h04);
    nxt(); nxt();

    // syscall with stall held 3 cycles; new flags during COMMIT are ignored
    bus.mem_valid = 1'b1; bus.ex_sys = 1'b1; bus.mem_pc = 32'h80000400;
    nxt();
    idle_in();
    bus.mem_stall = 1'b1; bus.mem_valid = 1'b1; bus.ex_ov = 1'b1; bus.mem_pc = 32'h9000_0000;
    en_cnt = 0;
    fl_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.exp_en) en_cnt++;
      if (bus.flush) fl_cnt++;
      if (k == 0) check("sys code", {27'h0, bus.exp_code}, 32'h08);
      nxt();
      if (k == 2) idle_in();
    end
    check("sys exp_en cycles", en_cnt, 32'd4);
    check("sys flush pulses", fl_cnt, 32'd1);

    // eret
    bus.mem_valid = 1'b1; bus.ex_eret = 1'b1; bus.epc_address = 32'h80002000;
    bus.mem_pc = 32'h80004000; bus.mem_bd = 1'b1;
    nxt(); idle_in(); bus.epc_address = 32'h12345678;
    @(negedge clk);
    check("eret exl_clean", {31'h0, bus.exl_clean}, 32'h1);
    check("eret epc", bus.exp_epc, 32'h80002000);
    check("eret bd", {31'h0, bus.exp_bd}, 32'h0);
    nxt();
    @(negedge clk);
    check("eret redirect", bus.redirect_pc, 32'h80002000);
    nxt(); idle_in();

    // interrupt beats RI; pc wrap in delay slot; reset during COMMIT
    bus.mem_valid = 1'b1; bus.allow_interrupt = 1'b1; bus.interrupt_flag = 8'h04;
    bus.ex_ri = 1'b1; bus.mem_pc = 32'h0; bus.mem_bd = 1'b1;
    nxt(); idle_in(); rst = 1'b0;
    @(negedge clk);
    check("int code", {27'h0, bus.exp_code}, 32'h00);
    check("int epc wrap", bus.exp_epc, 32'hFFFFFFFC);
    check("int badv_en", {31'h0, bus.exp_badvaddr_en}, 32'h0);
    nxt(); rst = 1'b1;
    @(negedge clk);
    check("rst exp_en", {31'h0, bus.exp_en}, 32'h0);
    check("rst flush", {31'h0, bus.flush}, 32'h0);
    nxt();
    @(negedge clk);
    check("rst no redirect", {31'h0, bus.redirect_valid}, 32'h0);

    // fetch AdEL outranks store AdES; interrupt masked by allow_interrupt=0
    bus.mem_valid = 1'b1; bus.ex_fetch_adel = 1'b1; bus.ex_store_ades = 1'b1;
    bus.mem_pc = 32'h80000101; bus.mem_addr = 32'h80000abd; bus.interrupt_flag = 8'hff;
    nxt(); idle_in();
    @(negedge clk);
    check("fetch badv", bus.exp_badvaddr, 32'h80000101);
    nxt(); nxt();

    // store AdES alone, then breakpoint
    bus.mem_valid = 1'b1; bus.ex_store_ades = 1'b1; bus.mem_pc = 32'h80000200;
    bus.mem_addr = 32'h80000abd;
    nxt(); idle_in();
    @(negedge clk);
    check("st code", {27'h0, bus.exp_code}, 32'h05);
    check("st badv", bus.exp_badvaddr, 32'h80000abd);
    nxt(); nxt();
    bus.mem_valid = 1'b1; bus.ex_bp = 1'b1; bus.ex_load_adel = 1'b1; bus.mem_pc = 32'h80000300;
    nxt(); idle_in();
    @(negedge clk);
    check("bp code", {27'h0, bus.exp_code}, 32'h09);
    nxt(); nxt();

    // flags without mem_valid do nothing
    bus.ex_ov = 1'b1; bus.allow_interrupt = 1'b1; bus.interrupt_flag = 8'h01;
    @(negedge clk);
    check("novalid stall", {31'h0, bus.exc_stall}, 32'h0);
    nxt(); idle_in();
    @(negedge clk);
    check("novalid exp_en", {31'h0, bus.exp_en}, 32'h0);

    // interrupt hint path
    bus.irq = 6'h21;
    @(negedge clk);
`ifdef EXC_IRQ_SYNC_EN
    check("hint cycle0", {26'h0, bus.hint}, 32'h00);
    nxt();
    @(negedge clk);
    check("hint cycle1", {26'h0, bus.hint}, 32'h00);
    nxt();
    @(negedge clk);
    check("hint cycle2", {26'h0, bus.hint}, 32'h21);
`else
    check("hint comb", {26'h0, bus.hint}, 32'h21);
`endif
    nxt(); nxt();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
